// File: rtl/io_stream_bridge.sv
// io_stream_bridge: peripheral-side counterpart of a single-cycle core's INPUT/OUTPUT ports.
//   Core OUTPUT words are pushed into a TX FIFO that drains to an external valid/ready sink.
//   An RX FIFO buffers words from an external valid/ready source and presents its head to
//   the core INPUT port. Both FIFOs are first-word fall-through.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cpu_out_data/strobe/full         core OUTPUT side (TX FIFO write)
//   cpu_in_data/strobe/avail         core INPUT side (RX FIFO read)
//   ext_tx_data/valid/ready          outgoing stream (TX FIFO head)
//   ext_rx_data/valid/ready          incoming stream (RX FIFO write)
//   tx_count, rx_count               FIFO occupancy, 0..DEPTH
//   tx_overflow, rx_underflow        sticky error flags, cleared by flag_clr
module io_stream_bridge #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    // core side
    input  logic [DATA_W-1:0]            cpu_out_data,
    input  logic                         cpu_out_strobe,
    output logic [DATA_W-1:0]            cpu_in_data,
    input  logic                         cpu_in_strobe,
    output logic                         cpu_in_avail,
    output logic                         cpu_out_full,
    // external TX stream
    output logic [DATA_W-1:0]            ext_tx_data,
    output logic                         ext_tx_valid,
    input  logic                         ext_tx_ready,
    // external RX stream
    input  logic [DATA_W-1:0]            ext_rx_data,
    input  logic                         ext_rx_valid,
    output logic                         ext_rx_ready,
    // status
    output logic [$clog2(DEPTH):0]       tx_count,
    output logic [$clog2(DEPTH):0]       rx_count,
    output logic                         tx_overflow,
    output logic                         rx_underflow,
    input  logic                         flag_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [DATA_W-1:0] rx_mem [DEPTH];

    logic [PTR_W-1:0]  tx_wr_q, tx_wr_d;
    logic [PTR_W-1:0]  tx_rd_q, tx_rd_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [PTR_W-1:0]  rx_wr_q, rx_wr_d;
    logic [PTR_W-1:0]  rx_rd_q, rx_rd_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              rx_unf_q, rx_unf_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic tx_push, tx_pop, tx_drop;
    logic rx_push, rx_pop, rx_miss;
    logic tx_nonempty, rx_nonempty;

    assign tx_nonempty = (tx_cnt_q != '0);
    assign rx_nonempty = (rx_cnt_q != '0);

    // TX pop frees a slot in the same cycle, so a push at full is still accepted
    assign tx_pop  = tx_nonempty && ext_tx_ready;
    assign tx_push = cpu_out_strobe && ((tx_cnt_q != FULL_CNT) || tx_pop);
    assign tx_drop = cpu_out_strobe && !tx_push;

    // RX ready depends only on occupancy, never on the core's read strobe
    assign ext_rx_ready = !rst && (rx_cnt_q != FULL_CNT);
    assign rx_push      = ext_rx_valid && ext_rx_ready;
    assign rx_pop       = cpu_in_strobe && rx_nonempty;
    assign rx_miss      = cpu_in_strobe && !rx_nonempty;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;

        // TX pointers and occupancy
        if (tx_push) begin
            tx_wr_d = tx_wr_q + PTR_W'(1);
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + PTR_W'(1);
        end
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end else if (tx_pop && !tx_push) begin
            tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end

        // RX pointers and occupancy
        if (rx_push) begin
            rx_wr_d = rx_wr_q + PTR_W'(1);
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + PTR_W'(1);
        end
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end else if (rx_pop && !rx_push) begin
            rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end

        // Sticky flags: a new event in the clearing cycle keeps the flag set
        if (flag_clr) begin
            tx_ovf_d = 1'b0;
            rx_unf_d = 1'b0;
        end
        if (tx_drop) begin
            tx_ovf_d = 1'b1;
        end
        if (rx_miss) begin
            rx_unf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    // Storage arrays carry no reset; contents are meaningless while the count is zero
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_q] <= cpu_out_data;
        end
        if (rx_push) begin
            rx_mem[rx_wr_q] <= ext_rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: heads fall through from registered storage
    // ------------------------------------------------------------------
    assign ext_tx_valid = tx_nonempty;
    assign ext_tx_data  = tx_mem[tx_rd_q];
    assign cpu_out_full = (tx_cnt_q == FULL_CNT);

    assign cpu_in_avail = rx_nonempty;
    assign cpu_in_data  = rx_nonempty ? rx_mem[rx_rd_q] : '0;

    assign tx_count     = tx_cnt_q;
    assign rx_count     = rx_cnt_q;
    assign tx_overflow  = tx_ovf_q;
    assign rx_underflow = rx_unf_q;

endmodule

// File: tb/tb_io_stream_bridge.sv
// Directed self-checking bench for io_stream_bridge (DATA_W=32, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_io_stream_bridge;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] cpu_out_data;
    logic              cpu_out_strobe;
    logic [DATA_W-1:0] cpu_in_data;
    logic              cpu_in_strobe;
    logic              cpu_in_avail;
    logic              cpu_out_full;
    logic [DATA_W-1:0] ext_tx_data;
    logic              ext_tx_valid;
    logic              ext_tx_ready;
    logic [DATA_W-1:0] ext_rx_data;
    logic              ext_rx_valid;
    logic              ext_rx_ready;
    logic [CNT_W-1:0]  tx_count;
    logic [CNT_W-1:0]  rx_count;
    logic              tx_overflow;
    logic              rx_underflow;
    logic              flag_clr;

    int n_pass;
    int n_chk;

    io_stream_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_out_data   (cpu_out_data),
        .cpu_out_strobe (cpu_out_strobe),
        .cpu_in_data    (cpu_in_data),
        .cpu_in_strobe  (cpu_in_strobe),
        .cpu_in_avail   (cpu_in_avail),
        .cpu_out_full   (cpu_out_full),
        .ext_tx_data    (ext_tx_data),
        .ext_tx_valid   (ext_tx_valid),
        .ext_tx_ready   (ext_tx_ready),
        .ext_rx_data    (ext_rx_data),
        .ext_rx_valid   (ext_rx_valid),
        .ext_rx_ready   (ext_rx_ready),
        .tx_count       (tx_count),
        .rx_count       (rx_count),
        .tx_overflow    (tx_overflow),
        .rx_underflow   (rx_underflow),
        .flag_clr       (flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tx_seq [3];
    logic [31:0] ovf_seq [4];
    int          accepted;

    initial begin
        n_pass         = 0;
        n_chk          = 0;
        rst            = 1'b1;
        cpu_out_data   = '0;
        cpu_out_strobe = 1'b0;
        cpu_in_strobe  = 1'b0;
        ext_tx_ready   = 1'b0;
        ext_rx_data    = '0;
        ext_rx_valid   = 1'b0;
        flag_clr       = 1'b0;
        tx_seq  = '{32'h11, 32'h22, 32'h33};
        ovf_seq = '{32'hA1, 32'hA2, 32'hA3, 32'hA5};

        // ---- reset and idle ----
        tick();
        check("rx_ready_in_rst", 32'(ext_rx_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_tx_valid",  32'(ext_tx_valid), 32'd0);
        check("rst_in_avail",  32'(cpu_in_avail), 32'd0);
        check("rst_in_data",   cpu_in_data, 32'd0);
        check("rst_out_full",  32'(cpu_out_full), 32'd0);
        check("rst_tx_count",  32'(tx_count), 32'd0);
        check("rst_rx_count",  32'(rx_count), 32'd0);
        check("rst_ovf",       32'(tx_overflow), 32'd0);
        check("rst_unf",       32'(rx_underflow), 32'd0);
        check("rx_ready_after", 32'(ext_rx_ready), 32'd1);

        // ---- TX basic: three words, then drain in order ----
        cpu_out_strobe = 1'b1;
        cpu_out_data   = 32'h11;
        tick();
        check("tx_first_valid", 32'(ext_tx_valid), 32'd1);
        check("tx_first_data",  ext_tx_data, 32'h11);
        cpu_out_data = 32'h22;
        tick();
        cpu_out_data = 32'h33;
        tick();
        cpu_out_strobe = 1'b0;
        check("tx_count3", 32'(tx_count), 32'd3);
        check("tx_head11", ext_tx_data, 32'h11);
        ext_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("tx_drain_data", ext_tx_data, tx_seq[i]);
            tick();
        end
        ext_tx_ready = 1'b0;
        check("tx_drained_valid", 32'(ext_tx_valid), 32'd0);
        check("tx_drained_count", 32'(tx_count), 32'd0);

        // ---- TX overflow: A0..A4 with sink stalled ----
        cpu_out_strobe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_out_data = 32'hA0 + 32'(i);
            tick();
            if (i == 3) begin
                check("tx_full_at4", 32'(cpu_out_full), 32'd1);
                check("tx_no_ovf_at4", 32'(tx_overflow), 32'd0);
            end
        end
        check("tx_ovf_set", 32'(tx_overflow), 32'd1);
        check("tx_count_full", 32'(tx_count), 32'd4);
        check("tx_head_a0", ext_tx_data, 32'hA0);
        // push and pop at full: accepted, count unchanged
        cpu_out_data = 32'hA5;
        ext_tx_ready = 1'b1;
        tick();
        ext_tx_ready = 1'b0;
        check("tx_pushpop_count", 32'(tx_count), 32'd4);
        check("tx_pushpop_head", ext_tx_data, 32'hA1);
        check("tx_pushpop_ovf", 32'(tx_overflow), 32'd1);
        // clear in same cycle as a new drop: set wins
        cpu_out_data = 32'hEE;
        flag_clr     = 1'b1;
        tick();
        check("tx_set_beats_clr", 32'(tx_overflow), 32'd1);
        cpu_out_strobe = 1'b0;
        tick();
        flag_clr = 1'b0;
        check("tx_ovf_clr", 32'(tx_overflow), 32'd0);
        // drain: A4 and EE were dropped
        ext_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("tx_ovf_drain", ext_tx_data, ovf_seq[i]);
            tick();
        end
        ext_tx_ready = 1'b0;
        check("tx_ovf_empty", 32'(ext_tx_valid), 32'd0);

        // ---- RX fill with a ready-honoring source ----
        accepted = 0;
        ext_rx_valid = 1'b1;
        for (int w = 1; w <= 6; w++) begin
            ext_rx_data = 32'(accepted + 1);
            if (ext_rx_ready) accepted = accepted + 1;
            tick();
        end
        ext_rx_valid = 1'b0;
        check("rx_accepted", 32'(accepted), 32'd4);
        check("rx_count4", 32'(rx_count), 32'd4);
        check("rx_ready_full", 32'(ext_rx_ready), 32'd0);
        check("rx_head1", cpu_in_data, 32'd1);
        check("rx_avail", 32'(cpu_in_avail), 32'd1);
        cpu_in_strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rx_pop_data", cpu_in_data, (i < 3) ? 32'(i + 2) : 32'd0);
        end
        cpu_in_strobe = 1'b0;
        check("rx_empty_avail", 32'(cpu_in_avail), 32'd0);
        check("rx_no_unf", 32'(rx_underflow), 32'd0);
        // refill after the pointers wrapped
        ext_rx_valid = 1'b1;
        ext_rx_data  = 32'd7;
        tick();
        ext_rx_data  = 32'd8;
        tick();
        ext_rx_valid = 1'b0;
        check("rx_wrap_count", 32'(rx_count), 32'd2);
        check("rx_wrap_head7", cpu_in_data, 32'd7);
        cpu_in_strobe = 1'b1;
        tick();
        check("rx_wrap_head8", cpu_in_data, 32'd8);
        tick();
        cpu_in_strobe = 1'b0;
        check("rx_wrap_empty", cpu_in_data, 32'd0);

        // ---- RX underflow with a simultaneous push ----
        cpu_in_strobe = 1'b1;
        ext_rx_valid  = 1'b1;
        ext_rx_data   = 32'h55;
        tick();
        cpu_in_strobe = 1'b0;
        ext_rx_valid  = 1'b0;
        check("rx_unf_set", 32'(rx_underflow), 32'd1);
        check("rx_unf_count", 32'(rx_count), 32'd1);
        check("rx_unf_data", cpu_in_data, 32'h55);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("rx_unf_clr", 32'(rx_underflow), 32'd0);
        cpu_in_strobe = 1'b1;
        tick();
        cpu_in_strobe = 1'b0;

        // ---- reset mid-burst: tx_count=2, rx_count=3 ----
        cpu_out_strobe = 1'b1;
        ext_rx_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_out_data   = 32'hC0 + 32'(i);
            ext_rx_data    = 32'hD0 + 32'(i);
            cpu_out_strobe = (i < 2);
            tick();
        end
        cpu_out_strobe = 1'b0;
        ext_rx_valid   = 1'b0;
        check("mid_tx_count", 32'(tx_count), 32'd2);
        check("mid_rx_count", 32'(rx_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_tx_valid", 32'(ext_tx_valid), 32'd0);
        check("arst_in_avail", 32'(cpu_in_avail), 32'd0);
        check("arst_tx_count", 32'(tx_count), 32'd0);
        check("arst_rx_count", 32'(rx_count), 32'd0);
        check("arst_in_data",  cpu_in_data, 32'd0);
        check("arst_rx_ready", 32'(ext_rx_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        cpu_out_strobe = 1'b1;
        cpu_out_data   = 32'h77;
        ext_rx_valid   = 1'b1;
        ext_rx_data    = 32'h99;
        tick();
        cpu_out_strobe = 1'b0;
        ext_rx_valid   = 1'b0;
        check("post_tx_count", 32'(tx_count), 32'd1);
        check("post_tx_data",  ext_tx_data, 32'h77);
        check("post_rx_count", 32'(rx_count), 32'd1);
        check("post_rx_data",  cpu_in_data, 32'h99);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
